// File: rtl/seq_burst_arbiter.sv
// Round-robin burst arbiter sharing one sequence_generator byte source among NREQ requesters.
// Optional build macro SEQ_ARB_ABORT_EN: dropping the owner's req during a burst ends it early.
module seq_burst_arbiter #(
    parameter int NREQ  = 4,
    parameter int LEN_W = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LEN_W-1:0] req_len,
    input  logic [7:0]            gen_data,
    output logic                  gen_enable,
    output logic [NREQ-1:0]       grant,
    output logic                  out_valid,
    output logic [7:0]            out_data,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PTR_W:0] NREQ_V = (PTR_W + 1)'(NREQ);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BURST = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] owner;
    logic [LEN_W:0]   count;

    logic [NREQ-1:0]  req_rot;
    logic             found;
    logic [PTR_W-1:0] offset;
    logic [PTR_W:0]   pick_sum;
    logic [PTR_W-1:0] pick;
    logic [LEN_W-1:0] pick_len;
    logic [LEN_W:0]   load_count;
    logic [PTR_W:0]   next_sum;
    logic [PTR_W-1:0] owner_next;
    logic             accept;
    logic             last_beat;
    logic             end_burst;

    // Rotate so that bit 0 is the requester at the pointer; the first set bit is the winner.
    always_comb begin
        req_rot = NREQ'({req, req} >> ptr);
        found   = 1'b0;
        offset  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req_rot[i]) begin
                found  = 1'b1;
                offset = i[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        pick_sum = {1'b0, ptr} + {1'b0, offset};
        if (pick_sum >= NREQ_V) begin
            pick = PTR_W'(pick_sum - NREQ_V);
        end else begin
            pick = pick_sum[PTR_W-1:0];
        end
        pick_len = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (pick == k[PTR_W-1:0]) begin
                pick_len = req_len[k*LEN_W +: LEN_W];
            end
        end
        // A zero length field means the full 2^LEN_W beats.
        load_count = (pick_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, pick_len};
    end

    always_comb begin
        next_sum   = {1'b0, owner} + (PTR_W + 1)'(1);
        owner_next = (next_sum >= NREQ_V) ? '0 : next_sum[PTR_W-1:0];
    end

    assign out_valid  = (state == BURST);
    assign out_data   = out_valid ? gen_data : '0;
    assign accept     = out_valid & out_ready;
    assign gen_enable = accept;
    assign busy       = (state == BURST) || (state == DONE);
    assign done       = (state == DONE);
    assign last_beat  = accept && (count == (LEN_W + 1)'(1));

`ifdef SEQ_ARB_ABORT_EN
    assign end_burst = last_beat || !(|(req & grant));
`else
    assign end_burst = last_beat;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= '0;
            owner <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state <= BURST;
                        owner <= pick;
                        grant <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
                        count <= load_count;
                    end
                end
                BURST: begin
                    if (accept) begin
                        count <= count - 1'b1;
                    end
                    if (end_burst) begin
                        state <= DONE;
                        grant <= '0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ptr   <= owner_next;
                    count <= '0;
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_burst_arbiter.sv
// Self-checking bench for seq_burst_arbiter: directed vector table, hand-written corner cases
// and randomized bursts against a transaction-level round-robin model.
module tb_seq_burst_arbiter;
    localparam int NREQ  = 4;
    localparam int LEN_W = 4;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*LEN_W-1:0] req_len = '0;
    logic [7:0]            gen_data;
    logic                  gen_enable;
    logic [NREQ-1:0]       grant;
    logic                  out_valid;
    logic [7:0]            out_data;
    logic                  out_ready = 1'b0;
    logic                  busy;
    logic                  done;

    seq_burst_arbiter #(.NREQ(NREQ), .LEN_W(LEN_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .req_len    (req_len),
        .gen_data   (gen_data),
        .gen_enable (gen_enable),
        .grant      (grant),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    // Stand-in sequence_generator: an 8-byte repeating sequence advanced by gen_enable.
    logic [7:0] seq [8] = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'h5A, 8'hC3, 8'h8D};
    logic [2:0] gidx;
    always @(posedge clock or posedge reset) begin
        if (reset) gidx <= '0;
        else if (gen_enable) gidx <= gidx + 3'd1;
    end
    assign gen_data = seq[gidx];

    int checks = 0;
    int errors = 0;
    int pos = 0;   // bytes consumed from the generator stream so far
    int ptr = 0;   // model round-robin pointer

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        req = '0;
        req_len = '0;
        out_ready = 1'b0;
        @(negedge clock);
        chk("rst_grant", grant, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_gen_en", gen_enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;
        pos = 0;
        ptr = 0;
    endtask

    // Starts at a negedge with the DUT idle; returns at the negedge of the following idle cycle.
    task automatic do_burst(input logic [NREQ-1:0] r, input logic [NREQ*LEN_W-1:0] l,
                            input logic [31:0] rdy, input int exp_w, input int exp_beats);
        int beats = 0;
        int cyc = 0;
        logic [31:0] exp_grant;
        exp_grant = 32'(1) << exp_w;
        req = r;
        req_len = l;
        out_ready = 1'b0;
        @(negedge clock);
        chk("grant", grant, exp_grant);
        chk("busy_burst", busy, 1);
        while (beats < exp_beats && cyc < 300) begin
            out_ready = (cyc < 32) ? rdy[cyc] : 1'b1;
            #1;
            chk("valid", out_valid, 1);
            chk("data", out_data, seq[pos % 8]);
            chk("gen_en", gen_enable, out_ready);
            chk("grant_hold", grant, exp_grant);
            chk("no_early_done", done, 0);
            @(posedge clock);
            if (out_ready) begin
                beats++;
                pos++;
            end
            cyc++;
            @(negedge clock);
        end
        if (beats < exp_beats) chk("burst_timeout", beats, exp_beats);
        out_ready = 1'b0;
        #1;
        chk("done_pulse", done, 1);
        chk("done_grant", grant, 0);
        chk("done_valid", out_valid, 0);
        chk("done_busy", busy, 1);
        chk("done_gen_en", gen_enable, 0);
        req = '0;
        ptr = (exp_w + 1) % NREQ;
        @(negedge clock);
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_grant", grant, 0);
    endtask

    typedef struct {
        logic                  rst;
        logic [NREQ-1:0]       req;
        logic [NREQ*LEN_W-1:0] len;
        logic [31:0]           rdy;
        int                    w;
        int                    beats;
    } vec_t;

    vec_t tbl [11];

    initial begin
        tbl[0]  = '{1'b0, 4'b0001, 16'h0003, 32'hFFFF_FFFF, 0, 3};
        tbl[1]  = '{1'b0, 4'b0100, 16'h0200, 32'hFFFF_FFFF, 2, 2};
        tbl[2]  = '{1'b1, 4'b1111, 16'h1111, 32'hFFFF_FFFF, 0, 1};
        tbl[3]  = '{1'b0, 4'b1111, 16'h1111, 32'hFFFF_FFFF, 1, 1};
        tbl[4]  = '{1'b0, 4'b1111, 16'h1111, 32'hFFFF_FFFF, 2, 1};
        tbl[5]  = '{1'b0, 4'b1111, 16'h1111, 32'hFFFF_FFFF, 3, 1};
        tbl[6]  = '{1'b0, 4'b1111, 16'h1111, 32'hFFFF_FFFF, 0, 1};
        tbl[7]  = '{1'b1, 4'b0001, 16'h0000, 32'hFFFF_FFFF, 0, 16};
        tbl[8]  = '{1'b0, 4'b0001, 16'h0003, 32'hFFFF_FFF9, 0, 3};
        tbl[9]  = '{1'b0, 4'b1001, 16'h4002, 32'hFFFF_FFFF, 3, 4};
        tbl[10] = '{1'b0, 4'b1001, 16'h4002, 32'hFFFF_FFFF, 0, 2};

        apply_reset();
        for (int i = 0; i < 11; i++) begin
            if (tbl[i].rst) apply_reset();
            do_burst(tbl[i].req, tbl[i].len, tbl[i].rdy, tbl[i].w, tbl[i].beats);
        end

        // Reset in the middle of a burst after one accepted beat.
        req = 4'b0001;
        req_len = 16'h0003;
        out_ready = 1'b1;
        @(negedge clock);
        chk("mr_grant", grant, 1);
        @(posedge clock);
        @(negedge clock);
        chk("mr_valid_before", out_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("mr_grant0", grant, 0);
        chk("mr_valid0", out_valid, 0);
        chk("mr_data0", out_data, 0);
        chk("mr_gen_en0", gen_enable, 0);
        chk("mr_busy0", busy, 0);
        chk("mr_done0", done, 0);
        @(negedge clock);
        chk("mr_no_done", done, 0);
        req = '0;
        out_ready = 1'b0;
        reset = 1'b0;
        pos = 0;
        ptr = 0;
        do_burst(4'b0001, 16'h0003, 32'hFFFF_FFFF, 0, 3);

`ifdef SEQ_ARB_ABORT_EN
        // Owner drops req during its second beat: that beat counts, then the burst ends.
        req = 4'b0001;
        req_len = 16'h0005;
        out_ready = 1'b1;
        @(negedge clock);
        chk("ab_grant", grant, 1);
        #1 chk("ab_data1", out_data, seq[pos % 8]);
        @(posedge clock);
        pos++;
        @(negedge clock);
        req = '0;
        #1;
        chk("ab_valid2", out_valid, 1);
        chk("ab_gen_en2", gen_enable, 1);
        chk("ab_data2", out_data, seq[pos % 8]);
        @(posedge clock);
        pos++;
        @(negedge clock);
        out_ready = 1'b0;
        #1;
        chk("ab_done", done, 1);
        chk("ab_valid_off", out_valid, 0);
        chk("ab_grant_off", grant, 0);
        ptr = 1;
        @(negedge clock);
        chk("ab_idle", busy, 0);
        do_burst(4'b0001, 16'h0002, 32'hFFFF_FFFF, 0, 2);
`endif

        // Randomized bursts against the round-robin model.
        for (int n = 0; n < 30; n++) begin
            logic [NREQ-1:0] r;
            logic [NREQ*LEN_W-1:0] l;
            logic [31:0] rdy;
            int w;
            int lv;
            r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            l = (NREQ*LEN_W)'($urandom);
            rdy = $urandom | $urandom;
            w = rr_pick(r);
            lv = int'((l >> (w * LEN_W)) & 16'hF);
            do_burst(r, l, rdy, w, (lv == 0) ? 16 : lv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
